tlcd_reader: RTL and testbench

TLCD_READER -- requirements
Module: tlcd_reader

---
 rtl/tlcd_pkg.sv | 20 ++
 rtl/tlcd_bus_cycle.sv | 106 ++++++++++
 rtl/tlcd_reader.sv | 154 +++++++++++++++
 tb/tb_tlcd_reader.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlcd_pkg.sv
// Shared definitions for the character-LCD read controller: controller
// states, the DDRAM address command and the busy-flag bit position.
package tlcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_WR,
        POLL,
        DATA_RD,
        BF_RD,
        DONE
    } state_e;

    // Set-DDRAM-address instruction; the low 7 bits carry the address.
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    // Busy flag position inside the status byte {BF, AC[6:0]}.
    localparam int BF_BIT = 7;

endpackage

// File: rtl/tlcd_bus_cycle.sv
// One LCD bus cycle: T_SETUP clocks with E low, T_EPW clocks with E high,
// T_HOLD clocks with E low. RS/RW/write data are latched when start_i is
// seen and only change on the first setup clock. A new cycle may be
// started on the same edge the previous one finishes.
module tlcd_bus_cycle #(
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 12,
    parameter int T_HOLD  = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       e_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic       oe_o,
    output logic [7:0] wdata_o,
    input  logic [7:0] data_in_i
);

    localparam int TOTAL = T_SETUP + T_EPW + T_HOLD;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] E_FIRST = CW'(T_SETUP);
    localparam logic [CW-1:0] E_LAST  = CW'(T_SETUP + T_EPW - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic          rw_q, rw_d;
    logic          oe_q, oe_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;

    assign done_o = active_q && (cnt_q == LAST);

    // Next-state for the phase counter and the latched pad controls.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch.
        active_d = active_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        rw_d     = rw_q;
        oe_d     = oe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
            rs_d     = rs_i;
            rw_d     = rw_i;
            oe_d     = !rw_i;
            wdata_d  = wdata_i;
        end else if (done_o) begin
            active_d = 1'b0;
            cnt_d    = '0;
            oe_d     = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        // E is registered so the strobe pin is glitch-free.
        e_d = active_d && (cnt_d >= E_FIRST) && (cnt_d <= E_LAST);
        // Read data is taken on the last E-high clock.
        if (active_q && rw_q && (cnt_q == E_LAST)) begin
            rdata_d = data_in_i;
        end
    end

    // Bus-cycle registers; reset drops E and OE immediately.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RESETN) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b1;
            oe_q     <= 1'b0;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            rw_q     <= rw_d;
            oe_q     <= oe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign e_o     = e_q;
    assign rs_o    = rs_q;
    assign rw_o    = rw_q;
    assign oe_o    = oe_q;
    assign wdata_o = wdata_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/tlcd_reader.sv
// Character-LCD read controller. Serves busy-flag/address reads and DDRAM
// data reads (set address, poll busy flag, read data) over a 4-wire-strobe
// 8-bit bus, returning a one-cycle response strobe.
module tlcd_reader
    import tlcd_pkg::*;
#(
    parameter int T_SETUP    = 2,
    parameter int T_EPW      = 12,
    parameter int T_HOLD     = 2,
    parameter int BF_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_DATA,
    input  logic [6:0] REQ_ADDR,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic       TLCD_E,
    output logic       TLCD_RS,
    output logic       TLCD_RW,
    output logic [7:0] TLCD_DATA_OUT,
    output logic       TLCD_DATA_OE,
    input  logic [7:0] TLCD_DATA_IN
);

    state_e     state_q, state_d;
    logic       ready_q;
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;

    logic       bus_start, bus_rs, bus_rw, bus_done;
    logic [7:0] bus_wdata, bus_rdata;

    logic accept, busy_flag, last_poll;

    assign accept    = REQ_VALID && ready_q;
    assign busy_flag = bus_rdata[BF_BIT];
    assign last_poll = (int'(poll_cnt_q) + 1) >= BF_TIMEOUT;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESETN) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ_DATA ? ADDR_WR : BF_RD;
            BF_RD:   if (bus_done) state_d = DONE;
            ADDR_WR: if (bus_done) state_d = POLL;
            POLL: begin
                if (bus_done) begin
                    if (!busy_flag)    state_d = DATA_RD;
                    else if (last_poll) state_d = DONE;
                end
            end
            DATA_RD: if (bus_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: bus-cycle launch, poll counter and response capture.
    always_comb begin
        bus_start  = 1'b0;
        bus_rs     = 1'b0;
        bus_rw     = 1'b1;
        bus_wdata  = 8'h00;
        poll_cnt_d = poll_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        // A cycle is launched whenever the next state needs the bus and the
        // bus is free (idle, or finishing on this edge), so cycles abut.
        if ((state_q == IDLE || bus_done) &&
            (state_d inside {ADDR_WR, POLL, DATA_RD, BF_RD})) begin
            bus_start = 1'b1;
        end
        case (state_d)
            ADDR_WR: begin
                bus_rw    = 1'b0;
                bus_wdata = CMD_SET_DDRAM | {1'b0, REQ_ADDR};
            end
            DATA_RD: bus_rs = 1'b1;
            default: ;
        endcase

        if (state_q != POLL && state_d == POLL) begin
            poll_cnt_d = 8'h00;
        end else if (state_q == POLL && bus_done && busy_flag) begin
            poll_cnt_d = (poll_cnt_q == 8'hFF) ? poll_cnt_q : poll_cnt_q + 8'd1;
        end

        if (bus_done && (state_q == BF_RD || state_q == DATA_RD)) begin
            rsp_data_d = bus_rdata;
            rsp_err_d  = 1'b0;
        end else if (state_q == POLL && state_d == DONE) begin
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b1;
        end
    end

    // Poll counter and held response registers.
    always_ff @(posedge CLK) begin
        if (RESETN) begin
            poll_cnt_q <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Ready is registered so it stays low through reset and rises one clock after release.
    always_ff @(posedge CLK) begin
        if (RESETN) ready_q <= 1'b0;
        else        ready_q <= (state_d == IDLE);
    end

    tlcd_bus_cycle #(
        .T_SETUP (T_SETUP),
        .T_EPW   (T_EPW),
        .T_HOLD  (T_HOLD)
    ) u_bus (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .start_i   (bus_start),
        .rs_i      (bus_rs),
        .rw_i      (bus_rw),
        .wdata_i   (bus_wdata),
        .done_o    (bus_done),
        .rdata_o   (bus_rdata),
        .e_o       (TLCD_E),
        .rs_o      (TLCD_RS),
        .rw_o      (TLCD_RW),
        .oe_o      (TLCD_DATA_OE),
        .wdata_o   (TLCD_DATA_OUT),
        .data_in_i (TLCD_DATA_IN)
    );

    assign REQ_READY = ready_q;
    assign RSP_VALID = (state_q == DONE);
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_tlcd_reader.sv
// Bench for tlcd_reader: an LCD pad model answers status and DDRAM reads,
// a negedge monitor checks bus-pin stability, and each test compares the
// response, latency and poll count against values derived from the
// request and the model's busy/memory settings.
module tb_tlcd_reader;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic       REQ_DATA = 1'b0;
    logic [6:0] REQ_ADDR = 7'h00;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic       RSP_ERR;
    logic       TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA_OE;
    logic [7:0] TLCD_DATA_OUT;
    logic [7:0] TLCD_DATA_IN;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    tlcd_reader dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_DATA      (REQ_DATA),
        .REQ_ADDR      (REQ_ADDR),
        .RSP_VALID     (RSP_VALID),
        .RSP_DATA      (RSP_DATA),
        .RSP_ERR       (RSP_ERR),
        .TLCD_E        (TLCD_E),
        .TLCD_RS       (TLCD_RS),
        .TLCD_RW       (TLCD_RW),
        .TLCD_DATA_OUT (TLCD_DATA_OUT),
        .TLCD_DATA_OE  (TLCD_DATA_OE),
        .TLCD_DATA_IN  (TLCD_DATA_IN)
    );

    // ---------------- LCD model ----------------
    // Owned by the stimulus: memory contents, status AC and busy settings.
    logic [7:0] ddram [128];
    logic [6:0] status_ac = 7'h00;
    int         busy_until = 0;
    bit         bf_stuck = 1'b0;
    // Owned by the monitor.
    int         status_rd_cnt = 0;
    int         pulse_cnt = 0;
    int         last_pulse = 0;
    int         chg_err = 0;
    int         oe_err = 0;
    int         rsp_cnt = 0;
    logic [6:0] ac_hw = 7'h00;
    logic [7:0] last_wr = 8'h00;
    bit         wr_oe_ok = 1'b0;
    bit         e_prev = 1'b0;
    int         e_run = 0;
    bit         oe_run = 1'b0;
    logic       rs_rise = 1'b0, rw_rise = 1'b0;
    logic [7:0] wd_rise = 8'h00;

    always_comb begin
        TLCD_DATA_IN = 8'h00;
        if (TLCD_E && TLCD_RW) begin
            if (TLCD_RS) TLCD_DATA_IN = ddram[ac_hw];
            else TLCD_DATA_IN = {bf_stuck || (status_rd_cnt < busy_until), status_ac};
        end
    end

    always @(negedge CLK) begin
        if (TLCD_E) begin
            if (!e_prev) begin
                rs_rise <= TLCD_RS;
                rw_rise <= TLCD_RW;
                wd_rise <= TLCD_DATA_OUT;
                e_run   <= 1;
                oe_run  <= TLCD_DATA_OE;
            end else begin
                if (TLCD_RS !== rs_rise || TLCD_RW !== rw_rise || TLCD_DATA_OUT !== wd_rise)
                    chg_err <= chg_err + 1;
                e_run  <= e_run + 1;
                oe_run <= oe_run & TLCD_DATA_OE;
            end
        end else if (e_prev) begin
            pulse_cnt  <= pulse_cnt + 1;
            last_pulse <= e_run;
            if (rw_rise) begin
                if (!rs_rise) status_rd_cnt <= status_rd_cnt + 1;
            end else begin
                last_wr  <= wd_rise;
                wr_oe_ok <= oe_run;
                if (!rs_rise && wd_rise[7]) ac_hw <= wd_rise[6:0];
            end
        end
        if (TLCD_DATA_OE && TLCD_RW) oe_err <= oe_err + 1;
        if (RSP_VALID) rsp_cnt <= rsp_cnt + 1;
        e_prev <= TLCD_E;
    end

    // ---------------- request driver ----------------
    // lat = clocks from acceptance to RSP_VALID, or -1 if a bound expired.
    // single = strobe lasted one clock, response held, and ready returned.
    task automatic do_request(input bit d, input logic [6:0] a, output int lat,
                              output logic [7:0] data, output logic err, output bit single);
        int n;
        lat = -1; data = 8'h00; err = 1'b0; single = 1'b0;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_DATA = d; REQ_ADDR = a;
        n = 0;
        while (!REQ_READY && n < 100) begin @(negedge CLK); n++; end
        if (!REQ_READY) begin REQ_VALID = 1'b0; #1; return; end
        n = 0;
        do begin
            @(negedge CLK); n++;
            if (n == 1) begin REQ_VALID = 1'b0; REQ_ADDR = ~a; end
        end while (!RSP_VALID && n < 6000);
        if (!RSP_VALID) begin #1; return; end
        lat = n; data = RSP_DATA; err = RSP_ERR;
        @(negedge CLK);
        single = !RSP_VALID && (RSP_DATA === data) && (RSP_ERR === err) && REQ_READY;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        tests_run++;
        if ({TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA_OE, TLCD_DATA_OUT} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_bus_pins: got E=%b RS=%b RW=%b OE=%b DO=%h expected 0 0 1 0 00",
                     TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA_OE, TLCD_DATA_OUT);
        end
        tests_run++;
        if ({REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_handshake: got RDY=%b RV=%b RD=%h RE=%b expected all 0",
                     REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR);
        end
        RESETN = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (REQ_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", REQ_READY);
        end
    endtask

    task automatic test_bf_read();
        int lat; logic [7:0] data; logic err; bit single; int p0, e0;
        status_ac = 7'h25; busy_until = status_rd_cnt;
        p0 = pulse_cnt; e0 = chg_err + oe_err;
        do_request(1'b0, 7'h11, lat, data, err, single);
        tests_run++;
        if (lat !== 17) begin tests_failed++; $display("FAIL bf_read_latency: got %0d expected 17", lat); end
        tests_run++;
        if ({data, err} !== {8'h25, 1'b0}) begin
            tests_failed++; $display("FAIL bf_read_data: got %h/%b expected 25/0", data, err);
        end
        tests_run++;
        if (single !== 1'b1) begin tests_failed++; $display("FAIL bf_read_strobe: got %b expected 1", single); end
        tests_run++;
        if (last_pulse !== 12 || pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL bf_read_epulse: got width %0d count %0d expected 12 1", last_pulse, pulse_cnt - p0);
        end
        tests_run++;
        if (chg_err + oe_err !== e0) begin
            tests_failed++; $display("FAIL bf_read_pins: got %0d violations expected 0", chg_err + oe_err - e0);
        end
    endtask

    task automatic test_data_read();
        int lat; logic [7:0] data; logic err; bit single; int s0, e0;
        ddram[7'h40] = 8'h46; busy_until = status_rd_cnt;
        s0 = status_rd_cnt; e0 = chg_err + oe_err;
        do_request(1'b1, 7'h40, lat, data, err, single);
        tests_run++;
        if (lat !== 49) begin tests_failed++; $display("FAIL data_read_latency: got %0d expected 49", lat); end
        tests_run++;
        if ({data, err} !== {8'h46, 1'b0}) begin
            tests_failed++; $display("FAIL data_read_data: got %h/%b expected 46/0", data, err);
        end
        tests_run++;
        if (last_wr !== 8'hC0 || wr_oe_ok !== 1'b1) begin
            tests_failed++; $display("FAIL data_read_addr_write: got %h oe=%b expected c0 oe=1", last_wr, wr_oe_ok);
        end
        tests_run++;
        if (status_rd_cnt - s0 !== 1) begin
            tests_failed++; $display("FAIL data_read_polls: got %0d expected 1", status_rd_cnt - s0);
        end
        tests_run++;
        if (chg_err + oe_err !== e0) begin
            tests_failed++; $display("FAIL data_read_pins: got %0d violations expected 0", chg_err + oe_err - e0);
        end
    endtask

    task automatic test_poll_retry();
        int lat; logic [7:0] data; logic err; bit single; int s0;
        logic [6:0] a;
        a = 7'($urandom);
        s0 = status_rd_cnt; busy_until = status_rd_cnt + 3;
        do_request(1'b1, a, lat, data, err, single);
        tests_run++;
        if (lat !== 97) begin tests_failed++; $display("FAIL poll_retry_latency: got %0d expected 97", lat); end
        tests_run++;
        if (status_rd_cnt - s0 !== 4) begin
            tests_failed++; $display("FAIL poll_retry_polls: got %0d expected 4", status_rd_cnt - s0);
        end
        tests_run++;
        if ({data, err} !== {ddram[a], 1'b0}) begin
            tests_failed++; $display("FAIL poll_retry_data: got %h/%b expected %h/0", data, err, ddram[a]);
        end
    endtask

    task automatic test_timeout();
        int lat; logic [7:0] data; logic err; bit single; int s0, e0;
        bf_stuck = 1'b1;
        s0 = status_rd_cnt; e0 = chg_err + oe_err;
        do_request(1'b1, 7'h05, lat, data, err, single);
        bf_stuck = 1'b0;
        tests_run++;
        if (status_rd_cnt - s0 !== 255) begin
            tests_failed++; $display("FAIL timeout_polls: got %0d expected 255", status_rd_cnt - s0);
        end
        tests_run++;
        if ({data, err} !== {8'h00, 1'b1}) begin
            tests_failed++; $display("FAIL timeout_rsp: got %h/%b expected 00/1", data, err);
        end
        tests_run++;
        if (lat !== 16 + 255 * 16 + 1) begin
            tests_failed++; $display("FAIL timeout_latency: got %0d expected %0d", lat, 16 + 255 * 16 + 1);
        end
        tests_run++;
        if (single !== 1'b1) begin tests_failed++; $display("FAIL timeout_strobe: got %b expected 1", single); end
        tests_run++;
        if (chg_err + oe_err !== e0) begin
            tests_failed++; $display("FAIL timeout_pins: got %0d violations expected 0", chg_err + oe_err - e0);
        end
    endtask

    task automatic test_back_to_back();
        int k, rsp_at, n;
        logic [6:0] ac1;
        ac1 = 7'($urandom);
        status_ac = ac1; busy_until = status_rd_cnt;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_DATA = 1'b0; REQ_ADDR = 7'h00;
        n = 0;
        while (!REQ_READY && n < 100) begin @(negedge CLK); n++; end
        k = 0; rsp_at = -1;
        do begin
            @(negedge CLK); k++;
            if (RSP_VALID && rsp_at < 0) rsp_at = k;
        end while (!REQ_READY && k < 100);
        tests_run++;
        if (k !== 18) begin tests_failed++; $display("FAIL b2b_accept_interval: got %0d expected 18", k); end
        tests_run++;
        if (rsp_at !== 17) begin tests_failed++; $display("FAIL b2b_first_rsp: got %0d expected 17", rsp_at); end
        // Second request is accepted on the coming edge.
        n = 0;
        do begin
            @(negedge CLK); n++;
            if (n == 1) REQ_VALID = 1'b0;
        end while (!RSP_VALID && n < 100);
        tests_run++;
        if (n !== 17 || RSP_DATA !== {1'b0, ac1}) begin
            tests_failed++;
            $display("FAIL b2b_second_rsp: got lat %0d data %h expected 17 %h", n, RSP_DATA, {1'b0, ac1});
        end
        @(negedge CLK);
    endtask

    task automatic test_random();
        int lat; logic [7:0] data; logic err; bit single; int s0, busy, exp_lat;
        bit d; logic [6:0] a; logic [7:0] exp_data;
        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom); a = 7'($urandom); busy = $urandom_range(0, 3);
            status_ac = 7'($urandom);
            s0 = status_rd_cnt; busy_until = status_rd_cnt + busy;
            if (d) begin
                exp_lat  = 16 + 16 * (busy + 1) + 16 + 1;
                exp_data = ddram[a];
            end else begin
                exp_lat  = 17;
                exp_data = {busy > 0, status_ac};
            end
            do_request(d, a, lat, data, err, single);
            tests_run++;
            if (lat !== exp_lat || data !== exp_data || err !== 1'b0 || single !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_%0d: got lat %0d data %h err %b single %b expected %0d %h 0 1",
                         i, lat, data, err, single, exp_lat, exp_data);
            end
            if (d) begin
                tests_run++;
                if (status_rd_cnt - s0 !== busy + 1) begin
                    tests_failed++;
                    $display("FAIL random_polls_%0d: got %0d expected %0d", i, status_rd_cnt - s0, busy + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_cycle();
        int n, k, r0, lat; logic [7:0] data; logic err; bit single;
        busy_until = status_rd_cnt;
        #1 r0 = rsp_cnt;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_DATA = 1'b1; REQ_ADDR = 7'h33;
        n = 0;
        while (!REQ_READY && n < 100) begin @(negedge CLK); n++; end
        @(negedge CLK); REQ_VALID = 1'b0;
        n = 0; k = 0;
        while (k < 5 && n < 100) begin
            if (TLCD_E === 1'b1) k++;
            if (k < 5) begin @(negedge CLK); n++; end
        end
        tests_run++;
        if (TLCD_DATA_OE !== 1'b1) begin
            tests_failed++; $display("FAIL rst_mid_oe_before: got %b expected 1", TLCD_DATA_OE);
        end
        RESETN = 1'b1;
        @(negedge CLK);
        tests_run++;
        if ({TLCD_E, TLCD_DATA_OE} !== 2'b00) begin
            tests_failed++; $display("FAIL rst_mid_drop: got E=%b OE=%b expected 0 0", TLCD_E, TLCD_DATA_OE);
        end
        @(negedge CLK);
        tests_run++;
        if (REQ_READY !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ready_low: got %b expected 0", REQ_READY); end
        RESETN = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready_rise: got %b expected 1", REQ_READY); end
        repeat (60) @(negedge CLK);
        #1;
        tests_run++;
        if (rsp_cnt !== r0) begin tests_failed++; $display("FAIL rst_mid_no_rsp: got %0d responses expected 0", rsp_cnt - r0); end
        status_ac = 7'h5A; busy_until = status_rd_cnt;
        do_request(1'b0, 7'h00, lat, data, err, single);
        tests_run++;
        if (lat !== 17 || data !== 8'h5A) begin
            tests_failed++; $display("FAIL rst_mid_recover: got %0d %h expected 17 5a", lat, data);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ddram[i] = 8'($urandom);
        test_reset();
        test_bf_read();
        test_data_read();
        test_poll_retry();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
